// File: rtl/leela_cam_arb_pkg.sv
// ============================================================================
// Module      : leela_cam_arb_pkg
// Description : Shared types and constants for the camera Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package leela_cam_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    // One-hot grant vectors presented on gnt_o
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT0     = 2'b01;
    localparam logic [1:0] GNT1     = 2'b10;

    // Default configuration
    localparam int DEF_BURST_MAX = 16;
    localparam int DEF_TIMEOUT   = 255;

    // Map FSM state to the one-hot grant vector
    function automatic logic [1:0] state_to_gnt(input arb_state_t s);
        case (s)
            ST_GNT0: state_to_gnt = GNT0;
            ST_GNT1: state_to_gnt = GNT1;
            default: state_to_gnt = GNT_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/leela_cam_arb_wdog.sv
// ============================================================================
// Module      : leela_cam_arb_wdog
// Description : 8-bit stall counter; pulses expired on the stalled cycle
//               that reaches the configured limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leela_cam_arb_wdog (
    input  logic       clk,
    input  logic       rst,
    input  logic       stb,
    input  logic       ack,
    input  logic       clr,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt;

    // Count cycles the strobe waits without an ack; saturate at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr || ack) begin
            cnt <= 8'd0;
        end else if (stb && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt holds the number of earlier stalled cycles, so the current stalled
    // cycle is number cnt+1
    assign expired = stb & ~ack & (cnt == (limit - 8'd1));

endmodule

`default_nettype wire

// File: rtl/leela_cam_wb_arb.sv
// ============================================================================
// Module      : leela_cam_wb_arb
// Description : Two-requester round-robin Wishbone arbiter with a per-grant
//               ack budget enforced by stalling the granted requester.
//               Define LEELA_CAM_ARB_WATCHDOG_EN to build the stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leela_cam_wb_arb
    import leela_cam_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] s0_adr_i,
    input  logic [DW-1:0] s0_dat_i,
    input  logic          s0_we_i,
    input  logic          s0_stb_i,
    input  logic          s0_cyc_i,
    input  logic [2:0]    s0_cti_i,
    input  logic [1:0]    s0_bte_i,
    output logic          s0_ack_o,
    output logic          s0_err_o,
    input  logic [AW-1:0] s1_adr_i,
    input  logic [DW-1:0] s1_dat_i,
    input  logic          s1_we_i,
    input  logic          s1_stb_i,
    input  logic          s1_cyc_i,
    input  logic [2:0]    s1_cti_i,
    input  logic [1:0]    s1_bte_i,
    output logic          s1_ack_o,
    output logic          s1_err_o,
    output logic [AW-1:0] m_adr_o,
    output logic [DW-1:0] m_dat_o,
    output logic          m_we_o,
    output logic          m_stb_o,
    output logic          m_cyc_o,
    output logic [2:0]    m_cti_o,
    output logic [1:0]    m_bte_o,
    input  logic          m_ack_i,
    input  logic          m_err_i,
    output logic [1:0]    gnt_o,
    output logic          timeout_o
);

    localparam logic [7:0] BUDGET   = 8'(BURST_MAX);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    arb_state_t state;
    logic       last_gnt;
    logic [7:0] ack_cnt;

    logic sel0, sel1;
    logic own_cyc, own_stb, other_cyc;
    logic stall, ack_seen, budget_hit, release_gnt, expired;

    // Grant selects are forced off while reset is held so every output is 0
    assign sel0 = (state == ST_GNT0) & ~rst;
    assign sel1 = (state == ST_GNT1) & ~rst;

    // Master port mux from the registered grant
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        other_cyc = 1'b0;
        m_adr_o   = '0;
        m_dat_o   = '0;
        m_we_o    = 1'b0;
        m_cti_o   = 3'b000;
        m_bte_o   = 2'b00;
        if (sel0) begin
            own_cyc   = s0_cyc_i;
            own_stb   = s0_stb_i;
            other_cyc = s1_cyc_i;
            m_adr_o   = s0_adr_i;
            m_dat_o   = s0_dat_i;
            m_we_o    = s0_we_i;
            m_cti_o   = s0_cti_i;
            m_bte_o   = s0_bte_i;
        end else if (sel1) begin
            own_cyc   = s1_cyc_i;
            own_stb   = s1_stb_i;
            other_cyc = s0_cyc_i;
            m_adr_o   = s1_adr_i;
            m_dat_o   = s1_dat_i;
            m_we_o    = s1_we_i;
            m_cti_o   = s1_cti_i;
            m_bte_o   = s1_bte_i;
        end
    end

    // Budget spent with the other side waiting: hold the owner off the bus
    // for the single cycle before the FSM drops back to IDLE
    assign stall   = other_cyc & (ack_cnt >= BUDGET);
    assign m_cyc_o = own_cyc & ~stall;
    assign m_stb_o = own_stb & ~stall;

    assign ack_seen    = m_ack_i & m_stb_o;
    assign budget_hit  = other_cyc & (({1'b0, ack_cnt} + {8'd0, ack_seen}) >= {1'b0, BUDGET});
    assign release_gnt = (sel0 | sel1) & (~own_cyc | budget_hit | expired);

    assign s0_ack_o = sel0 & ack_seen;
    assign s1_ack_o = sel1 & ack_seen;
    assign s0_err_o = sel0 & ((m_err_i & m_stb_o) | expired);
    assign s1_err_o = sel1 & ((m_err_i & m_stb_o) | expired);

    assign gnt_o = rst ? GNT_NONE : state_to_gnt(state);

    // Arbitration FSM: round-robin pick from IDLE, release on drop/budget/abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
            ack_cnt  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_cnt <= 8'd0;
                    if (s0_cyc_i && (!s1_cyc_i || last_gnt)) begin
                        state <= ST_GNT0;
                    end else if (s1_cyc_i) begin
                        state <= ST_GNT1;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (release_gnt) begin
                        state    <= ST_IDLE;
                        last_gnt <= (state == ST_GNT1);
                    end else if (ack_seen && (ack_cnt != 8'hFF)) begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LEELA_CAM_ARB_WATCHDOG_EN
    logic timeout_q;

    leela_cam_arb_wdog u_wdog (
        .clk     (clk),
        .rst     (rst),
        .stb     (m_stb_o),
        .ack     (m_ack_i),
        .clr     (~(sel0 | sel1)),
        .limit   (TO_LIMIT),
        .expired (expired)
    );

    // Sticky abort flag, only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q & ~rst;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_LIMIT;
    assign expired   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_leela_cam_wb_arb.sv
// ============================================================================
// Module      : tb_leela_cam_wb_arb
// Description : Directed self-checking bench for leela_cam_wb_arb
//               (BURST_MAX=4, TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leela_cam_wb_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s0_adr_i, s0_dat_i, s1_adr_i, s1_dat_i;
    logic        s0_we_i, s0_stb_i, s0_cyc_i, s1_we_i, s1_stb_i, s1_cyc_i;
    logic [2:0]  s0_cti_i, s1_cti_i;
    logic [1:0]  s0_bte_i, s1_bte_i;
    logic        s0_ack_o, s0_err_o, s1_ack_o, s1_err_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_we_o, m_stb_o, m_cyc_o;
    logic [2:0]  m_cti_o;
    logic [1:0]  m_bte_o;
    logic        m_ack_i, m_err_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    logic        ack_en = 1'b0;
    int          rem0, rem1, done0, done1;
    int          checks = 0;
    int          errors = 0;
    int          idx;

    logic [1:0]  lg_gnt [0:63];
    logic        lg_a0  [0:63];
    logic        lg_a1  [0:63];
    logic        lg_e0  [0:63];
    logic        lg_e1  [0:63];
    logic        lg_cyc [0:63];
    logic        lg_to  [0:63];
    logic [31:0] lg_adr [0:63];
    logic [31:0] lg_dat [0:63];
    logic [2:0]  lg_cti [0:63];

    always #5 clk = ~clk;

    // Memory controller: zero-wait-state ack while enabled
    assign m_ack_i = ack_en & m_stb_o;

    leela_cam_wb_arb #(
        .AW(32), .DW(32), .BURST_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_adr_i(s0_adr_i), .s0_dat_i(s0_dat_i), .s0_we_i(s0_we_i),
        .s0_stb_i(s0_stb_i), .s0_cyc_i(s0_cyc_i), .s0_cti_i(s0_cti_i),
        .s0_bte_i(s0_bte_i), .s0_ack_o(s0_ack_o), .s0_err_o(s0_err_o),
        .s1_adr_i(s1_adr_i), .s1_dat_i(s1_dat_i), .s1_we_i(s1_we_i),
        .s1_stb_i(s1_stb_i), .s1_cyc_i(s1_cyc_i), .s1_cti_i(s1_cti_i),
        .s1_bte_i(s1_bte_i), .s1_ack_o(s1_ack_o), .s1_err_o(s1_err_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o),
        .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_cti_o(m_cti_o),
        .m_bte_o(m_bte_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    // Requester pins follow the outstanding write counts
    task automatic drive();
        s0_cyc_i = (rem0 > 0);
        s0_stb_i = (rem0 > 0);
        s0_we_i  = (rem0 > 0);
        s0_adr_i = 32'h0000_0100 + 32'(done0 * 4);
        s0_dat_i = 32'hA000_0000 + 32'(done0);
        s0_cti_i = 3'b010;
        s0_bte_i = 2'b01;
        s1_cyc_i = (rem1 > 0);
        s1_stb_i = (rem1 > 0);
        s1_we_i  = (rem1 > 0);
        s1_adr_i = 32'h0000_8000 + 32'(done1 * 4);
        s1_dat_i = 32'hB000_0000 + 32'(done1);
        s1_cti_i = 3'b111;
        s1_bte_i = 2'b10;
    endtask

    // One bus cycle: log outputs at negedge, then advance requesters
    task automatic step();
        @(negedge clk);
        if (idx < 64) begin
            lg_gnt[idx] = gnt_o;   lg_a0[idx]  = s0_ack_o; lg_a1[idx] = s1_ack_o;
            lg_e0[idx]  = s0_err_o; lg_e1[idx] = s1_err_o; lg_cyc[idx] = m_cyc_o;
            lg_to[idx]  = timeout_o; lg_adr[idx] = m_adr_o; lg_dat[idx] = m_dat_o;
            lg_cti[idx] = m_cti_o;
        end
        idx++;
        if (s0_ack_o) begin rem0--; done0++; end
        if (s1_ack_o) begin rem1--; done1++; end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1; rem0 = 0; rem1 = 0; done0 = 0; done1 = 0;
        m_err_i = 1'b0; ack_en = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rem0 = 1; rem1 = 1; m_err_i = 1'b0; ack_en = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (gnt_o !== 2'b00 || m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || s0_ack_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b cyc=%b stb=%b ack0=%b to=%b, want all 0", gnt_o, m_cyc_o, m_stb_o, s0_ack_o, timeout_o);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (gnt_o !== 2'b00 || m_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b adr=%h, want 00 / 0", gnt_o, m_adr_o);
        end
    endtask

    task automatic test_single();
        int n0, n1;
        do_reset();
        ack_en = 1'b1; rem0 = 3; idx = 0;
        drive();
        repeat (6) step();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin n0 += int'(lg_a0[i]); n1 += int'(lg_a1[i]); end
        checks++;
        if (lg_gnt[0] !== 2'b00 || lg_gnt[1] !== 2'b01 || lg_cyc[1] !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: gnt c0=%b c1=%b cyc=%b, want 00 01 1", lg_gnt[0], lg_gnt[1], lg_cyc[1]);
        end
        checks++;
        if (lg_adr[1] !== 32'h100 || lg_dat[1] !== 32'hA000_0000 || lg_cti[1] !== 3'b010) begin
            errors++;
            $display("FAIL single_mux: adr=%h dat=%h cti=%b, want 100 a0000000 010", lg_adr[1], lg_dat[1], lg_cti[1]);
        end
        checks++;
        if (lg_adr[3] !== 32'h108 || lg_dat[3] !== 32'hA000_0002) begin
            errors++;
            $display("FAIL single_third: adr=%h dat=%h, want 108 a0000002", lg_adr[3], lg_dat[3]);
        end
        checks++;
        if (n0 != 3 || n1 != 0) begin
            errors++;
            $display("FAIL single_acks: s0=%0d s1=%0d, want 3 0", n0, n1);
        end
        checks++;
        if (lg_gnt[4] !== 2'b01 || lg_cyc[4] !== 1'b0 || lg_gnt[5] !== 2'b00) begin
            errors++;
            $display("FAIL single_release: gnt c4=%b cyc=%b gnt c5=%b, want 01 0 00", lg_gnt[4], lg_cyc[4], lg_gnt[5]);
        end
    endtask

    task automatic test_both();
        logic [1:0] exp_g [0:8];
        exp_g = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
        do_reset();
        ack_en = 1'b1; rem0 = 2; rem1 = 2; idx = 0;
        drive();
        repeat (9) step();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (lg_gnt[i] !== exp_g[i]) begin
                errors++;
                $display("FAIL both_gnt[%0d]: got %b want %b", i, lg_gnt[i], exp_g[i]);
            end
        end
        checks++;
        if (lg_a1[5] !== 1'b1 || lg_adr[5] !== 32'h8000 || lg_cti[5] !== 3'b111 || lg_a0[5] !== 1'b0) begin
            errors++;
            $display("FAIL both_s1: ack1=%b adr=%h cti=%b ack0=%b, want 1 8000 111 0", lg_a1[5], lg_adr[5], lg_cti[5], lg_a0[5]);
        end
    endtask

    task automatic test_budget();
        logic [1:0] exp_g [0:17];
        logic       exp_a0 [0:17];
        exp_g  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2,
                   2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        exp_a0 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        ack_en = 1'b1; rem0 = 10; rem1 = 2; idx = 0;
        drive();
        repeat (18) step();
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (lg_gnt[i] !== exp_g[i] || lg_a0[i] !== exp_a0[i]) begin
                errors++;
                $display("FAIL budget[%0d]: gnt=%b ack0=%b, want %b %b", i, lg_gnt[i], lg_a0[i], exp_g[i], exp_a0[i]);
            end
        end
        checks++;
        if (lg_cyc[5] !== 1'b0 || lg_a1[6] !== 1'b1 || lg_a1[7] !== 1'b1 || rem0 != 0 || rem1 != 0) begin
            errors++;
            $display("FAIL budget_handover: cyc c5=%b ack1 c6=%b c7=%b rem0=%0d rem1=%0d, want 0 1 1 0 0",
                     lg_cyc[5], lg_a1[6], lg_a1[7], rem0, rem1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_en = 1'b0; rem1 = 5; idx = 0;
        drive();
        repeat (2) step();
        checks++;
        if (lg_gnt[1] !== 2'b10 || lg_cyc[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: gnt=%b cyc=%b, want 10 1", lg_gnt[1], lg_cyc[1]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt_o !== 2'b00 || m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || s1_ack_o !== 1'b0 || m_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_held: gnt=%b cyc=%b stb=%b ack1=%b adr=%h, want all 0", gnt_o, m_cyc_o, m_stb_o, s1_ack_o, m_adr_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; ack_en = 1'b1; rem0 = 1; idx = 0;
        drive();
        repeat (2) step();
        checks++;
        if (lg_gnt[0] !== 2'b00 || lg_cyc[0] !== 1'b0 || lg_a1[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: gnt=%b cyc=%b ack1=%b, want 00 0 0", lg_gnt[0], lg_cyc[0], lg_a1[0]);
        end
        checks++;
        if (lg_gnt[1] !== 2'b01 || lg_a0[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_rearb: gnt=%b ack0=%b, want 01 1", lg_gnt[1], lg_a0[1]);
        end
    endtask

    task automatic test_err();
        do_reset();
        ack_en = 1'b0; rem1 = 1; idx = 0;
        drive();
        step();
        m_err_i = 1'b1;
        step();
        checks++;
        if (lg_e1[1] !== 1'b1 || lg_e0[1] !== 1'b0 || lg_a1[1] !== 1'b0) begin
            errors++;
            $display("FAIL err_route: err1=%b err0=%b ack1=%b, want 1 0 0", lg_e1[1], lg_e0[1], lg_a1[1]);
        end
        m_err_i = 1'b0; rem1 = 0;
        drive();
        repeat (2) step();
    endtask

    task automatic test_watchdog();
        int    ne;
        logic  wd;
        logic  [1:0] exp_g9;
`ifdef LEELA_CAM_ARB_WATCHDOG_EN
        wd = 1'b1; exp_g9 = 2'b00;
`else
        wd = 1'b0; exp_g9 = 2'b01;
`endif
        do_reset();
        ack_en = 1'b0; rem0 = 1; idx = 0;
        drive();
        repeat (10) step();
        ne = 0;
        for (int i = 0; i < 10; i++) ne += int'(lg_e0[i]);
        checks++;
        if (ne != int'(wd) || lg_e0[8] !== wd) begin
            errors++;
            $display("FAIL wdog_err: pulses=%0d err0 c8=%b, want %0d %b", ne, lg_e0[8], int'(wd), wd);
        end
        checks++;
        if (lg_gnt[9] !== exp_g9 || lg_to[9] !== wd || lg_to[7] !== 1'b0) begin
            errors++;
            $display("FAIL wdog_state: gnt c9=%b to c9=%b to c7=%b, want %b %b 0", lg_gnt[9], lg_to[9], lg_to[7], exp_g9, wd);
        end
        rem0 = 0;
        drive();
        repeat (3) step();
        checks++;
        if (timeout_o !== wd) begin
            errors++;
            $display("FAIL wdog_sticky: to=%b want %b", timeout_o, wd);
        end
    endtask

    initial begin
        idx = 0; rem0 = 0; rem1 = 0; done0 = 0; done1 = 0; m_err_i = 1'b0;
        drive();
        test_reset();
        test_single();
        test_both();
        test_budget();
        test_reset_mid();
        test_err();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/leela_cam_wb_arb.md
# leela_cam_wb_arb

Two-requester Wishbone arbiter sharing one memory-controller master port between the camera's VGA pixel-write stream (requester 0) and filtered-bitmap write stream (requester 1). Sits between the camera capture block's two single-write Wishbone master outputs and the memory controller port. Applies round-robin fairness with a bounded per-grant write budget, enforced by stalling the granted requester. Optionally aborts stuck transfers with a watchdog.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- BURST_MAX, 16, acks allowed per grant while the other requester waits (2..255)
- TIMEOUT, 255, watchdog limit in cycles (8-bit, 1..255)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- s0_adr_i / s1_adr_i  in  AW  requester address
- s0_dat_i / s1_dat_i  in  DW  write data
- s0_we_i, s0_stb_i, s0_cyc_i / s1_*  in  1 each  Wishbone controls
- s0_cti_i / s1_cti_i  in  3  cycle type, passed through
- s0_bte_i / s1_bte_i  in  2  burst type, passed through
- s0_ack_o / s1_ack_o  out  1  routed ack
- s0_err_o / s1_err_o  out  1  routed error or watchdog abort
- m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o, m_cti_o, m_bte_o  out  AW/DW/1/1/1/3/2  shared master port
- m_ack_i, m_err_i  in  1 each  from memory controller
- gnt_o  out  2  one-hot current grant, 00 when idle
- timeout_o  out  1  sticky watchdog flag, cleared only by rst

## Operation
- States: IDLE, GNT0, GNT1. last_gnt register, reset value 1.
- IDLE: the requester with cyc high is granted next cycle. If both, grant the one != last_gnt. If none, stay in IDLE.
- GNTx: master outputs are muxed from sx_*. m_cyc_o = sx_cyc_i and m_stb_o = sx_stb_i, gated by the stall condition. sx_ack_o = m_ack_i & m_stb_o. sx_err_o likewise. The other requester's ack and err stay 0.
- Ack counter, 8 bits: clears on entry to GNTx and increments on each m_ack_i.
- Leave GNTx and return to IDLE, setting last_gnt = x, when either:
  - sx_cyc_i drops; or
  - the counter reaches BURST_MAX while the other cyc is high.
- On budget exhaustion, x keeps cyc high and is stalled: no ack until it is re-granted. Wishbone slave stall makes this legal.
- Non-granted m_* outputs and all acks are 0 in IDLE.

## Timing
- Grant latency: cyc asserted in IDLE → gnt_o and m_cyc_o high on the next cycle. There is one IDLE cycle between any two grants, so m_cyc_o is low for at least one cycle.
- Ack and err paths are combinational (zero cycles). Master output mux is combinational from the registered state.
- The budget-exhausting ack is still delivered. m_stb_o drops on the next edge.
- Simultaneous cyc drop and budget exhaustion: treat as a normal release.
- Reset at any point: next edge gives state IDLE, gnt_o=00, counters 0, timeout_o=0, last_gnt=1. All outputs are 0 while rst is high.

## Configuration
- LEELA_CAM_ARB_WATCHDOG_EN defined:
  - A counter increments each cycle m_stb_o is high without m_ack_i, and clears on ack or state change.
  - When it reaches TIMEOUT, assert sx_err_o for one cycle, set timeout_o, and force the state to IDLE.
  - The counter is a separate block.
- Not defined: no counter is built, timeout_o ties to 0, and errors come only from m_err_i.

## Structure
- Package leela_cam_arb_pkg holds:
  - state enum (IDLE=0, GNT0=1, GNT1=2)
  - GNT_NONE/GNT0/GNT1 one-hot constants
  - default BURST_MAX and TIMEOUT
- Sub-module leela_cam_arb_wdog: 8-bit stall counter. Inputs: clk, rst, stb, ack, clr, limit. Output: expired pulse. Instantiated only under the macro.

## Test plan
- s0 alone, 3 writes with 1-cycle ack → gnt_o=01 one cycle after cyc. m_adr_o/m_dat_o equal s0 values. 3 s0 acks. gnt_o=00 after s0 cyc drops.
- s0 and s1 cyc high in the same IDLE cycle after reset → s0 granted first (last_gnt=1). After s0 releases, s1 is granted following one IDLE cycle.
- BURST_MAX=4, s0 streams 10 writes, s1 waits → exactly 4 s0 acks, then m_cyc_o low 1 cycle, then s1 granted. s0 resumes after s1 releases.
- rst asserted mid-GNT1 with m_stb_o high → next cycle all m_* 0, gnt_o=00, s1_ack_o=0. Re-arbitration picks s0 first.
- Macro on, TIMEOUT=8, m_ack_i held 0 → s0_err_o pulses once on the 8th stalled cycle, timeout_o=1, state IDLE. Macro off, same stimulus → hangs in GNT0 and timeout_o=0.
